read_string: RTL

Console-input syscall engine: on a pulse of `start` it accepts characters from a byte-wide console stream and packs them four per word into data memory starting at the buffer address in `a0`. It stops at the length limit in `a1` or at a terminator character, then null-terminates the buffer. It is the write-side counterpart of the string-print path: the print path reads packed words from memory and emits characters, and this block takes characters in and writes packed words to memory. It sits beside the data memory and is driven by the syscall decode.

---
 rtl/read_string_pkg.sv | 23 ++
 rtl/byte_to_word_packer.sv | 35 +++
 rtl/read_string.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/read_string_pkg.sv
// ============================================================================
// Module      : read_string_pkg
// Description : Shared types and constants for the read_string syscall engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package read_string_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    localparam logic [7:0] NUL                 = 8'h00;
    localparam logic [7:0] c_default_term_char = 8'h0A;
    localparam int         c_lane_w            = 2;
    localparam int         c_lanes_per_word    = 4;

endpackage

`default_nettype wire

// File: rtl/byte_to_word_packer.sv
// ============================================================================
// Module      : byte_to_word_packer
// Description : Inserts a byte into a word lane, zero-fills the lanes above it
//               and flags when the top lane has been filled.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_to_word_packer
    import read_string_pkg::*;
(
    input  logic [31:0]         i_word,
    input  logic [c_lane_w-1:0] i_lane,
    input  logic [7:0]          i_byte,
    output logic [31:0]         o_word,
    output logic                o_word_full
);

    // Zero-filling above the lane means a word never needs clearing between
    // uses, and the null terminator falls out of the same path for free.
    always_comb begin
        o_word = i_word;
        for (int k = 0; k < c_lanes_per_word; k++) begin
            if (c_lane_w'(k) == i_lane) begin
                o_word[8*k +: 8] = i_byte;
            end else if (c_lane_w'(k) > i_lane) begin
                o_word[8*k +: 8] = NUL;
            end
        end
        o_word_full = (i_lane == c_lane_w'(c_lanes_per_word - 1));
    end

endmodule

`default_nettype wire

// File: rtl/read_string.sv
// ============================================================================
// Module      : read_string
// Description : Console-input syscall engine: packs received characters four
//               per word into memory, then null-terminates the buffer.
//               Optional console echo under `READ_STRING_ECHO_EN`.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module read_string
    import read_string_pkg::*;
#(
    parameter logic [7:0] TERM_CHAR = c_default_term_char
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a0,
    input  logic [31:0] a1,
    input  logic [7:0]  rx_char,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        mem_wr_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] count
);

    state_t      r_state, w_state_nxt;
    logic [31:0] r_base, w_base_nxt;
    logic [31:0] r_limit, w_limit_nxt;
    logic [31:0] r_word, w_word_nxt;
    logic        w_rx_ready_nxt, w_wr_en_nxt, w_busy_nxt, w_done_nxt;
    logic [31:0] w_addr_nxt, w_wdata_nxt, w_count_nxt;
    logic        w_accept, w_word_full, w_term;
    logic [7:0]  w_lane_byte;
    logic [31:0] w_packed, w_count_inc, w_word_addr;

    assign w_accept    = (r_state == S_RECV) && rx_valid && rx_ready;
    assign w_lane_byte = (r_state == S_RECV) ? rx_char : NUL;
    assign w_count_inc = count + 32'd1;
    assign w_word_addr = r_base + {count[31:2], 2'b00};
    assign w_term      = (rx_char == TERM_CHAR) || (w_count_inc == r_limit);

    byte_to_word_packer u_packer (
        .i_word      (r_word),
        .i_lane      (count[c_lane_w-1:0]),
        .i_byte      (w_lane_byte),
        .o_word      (w_packed),
        .o_word_full (w_word_full)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_base_nxt     = r_base;
        w_limit_nxt    = r_limit;
        w_word_nxt     = r_word;
        w_rx_ready_nxt = rx_ready;
        w_wr_en_nxt    = 1'b0;
        w_addr_nxt     = mem_addr;
        w_wdata_nxt    = mem_wdata;
        w_busy_nxt     = busy;
        w_done_nxt     = 1'b0;
        w_count_nxt    = count;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_base_nxt  = {a0[31:2], 2'b00};
                    w_limit_nxt = a1 - 32'd1;
                    w_count_nxt = 32'd0;
                    if (a1 == 32'd0) begin
                        w_done_nxt = 1'b1;
                    end else if (a1 == 32'd1) begin
                        w_state_nxt = S_FLUSH;
                        w_busy_nxt  = 1'b1;
                    end else begin
                        w_state_nxt    = S_RECV;
                        w_busy_nxt     = 1'b1;
                        w_rx_ready_nxt = 1'b1;
                    end
                end
            end

            S_RECV: begin
                if (w_accept) begin
                    w_word_nxt  = w_packed;
                    w_count_nxt = w_count_inc;
                    if (w_word_full || w_term) begin
                        w_wr_en_nxt = 1'b1;
                        w_addr_nxt  = w_word_addr;
                        w_wdata_nxt = w_packed;
                    end
                    if (w_term) begin
                        w_rx_ready_nxt = 1'b0;
                        // A partial word already carries the null in the lane
                        // above the terminator, so the flush write is this one.
                        if (w_word_full) begin
                            w_state_nxt = S_FLUSH;
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_done_nxt  = 1'b1;
                            w_busy_nxt  = 1'b0;
                        end
                    end
                end
            end

            S_FLUSH: begin
                w_wr_en_nxt = 1'b1;
                w_addr_nxt  = w_word_addr;
                w_wdata_nxt = w_packed;
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt    = S_IDLE;
                w_rx_ready_nxt = 1'b0;
                w_busy_nxt     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_base    <= 32'd0;
            r_limit   <= 32'd0;
            r_word    <= 32'd0;
            rx_ready  <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            count     <= 32'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_base    <= w_base_nxt;
            r_limit   <= w_limit_nxt;
            r_word    <= w_word_nxt;
            rx_ready  <= w_rx_ready_nxt;
            mem_wr_en <= w_wr_en_nxt;
            mem_addr  <= w_addr_nxt;
            mem_wdata <= w_wdata_nxt;
            busy      <= w_busy_nxt;
            done      <= w_done_nxt;
            count     <= w_count_nxt;
        end
    end

`ifdef READ_STRING_ECHO_EN
    always_ff @(posedge clk) begin
        if (!reset && w_accept) begin
            $write("%s", rx_char);
        end
        if (!reset && w_done_nxt) begin
            $display("");
        end
    end
`endif

endmodule

`default_nettype wire
